// File: rtl/freq_scan_ctrl.sv
// Ring-oscillator scan sequencer: selects each oscillator, runs the meter
// 2**AVG_LOG2 times, and emits one summed result record per oscillator.
module freq_scan_ctrl #(
  parameter int N_OSC    = 16,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 16,
  parameter int TIMEOUT  = 65536
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [SEL_W-1:0]          osc_sel,
  output logic                      meas_enable,
  input  logic                      meas_lock,
  input  logic [CNT_W-1:0]          meas_count,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SEL_W-1:0]          res_osc,
  output logic [CNT_W+AVG_LOG2-1:0] res_sum,
  output logic                      res_err
);

  localparam int SW   = CNT_W + AVG_LOG2;
  localparam int REPS = 1 << AVG_LOG2;
  localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CLEAR,
    S_MEASURE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_osc;
  logic [SW-1:0]    r_acc;
  logic [RW-1:0]    r_rep;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic w_settled;
  logic w_timeout;
  logic w_last_rep;
  logic w_last_osc;

  assign w_settled  = (r_cnt == CW'(SETTLE - 1));
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_last_rep = (r_rep == RW'(REPS - 1));
  assign w_last_osc = (r_osc == SEL_W'(N_OSC - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_osc       <= '0;
      r_acc       <= '0;
      r_rep       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      osc_sel     <= '0;
      meas_enable <= 1'b0;
      res_valid   <= 1'b0;
      res_osc     <= '0;
      res_sum     <= '0;
      res_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SELECT;
            busy    <= 1'b1;
            r_osc   <= '0;
            osc_sel <= '0;
            r_acc   <= '0;
            r_rep   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_SELECT: begin
          if (w_settled) begin
            r_cnt   <= '0;
            r_state <= S_CLEAR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLEAR: begin
          // lock still high means the meter has not yet flushed its old count
          if (!meas_lock) begin
            r_cnt       <= '0;
            meas_enable <= 1'b1;
            r_state     <= S_MEASURE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_MEASURE: begin
          if (meas_lock) begin
            meas_enable <= 1'b0;
            r_acc       <= r_acc + SW'(meas_count);
            r_state     <= S_CAPTURE;
          end else if (w_timeout) begin
            meas_enable <= 1'b0;
            r_err       <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          r_rep <= r_rep + RW'(1);
          if (w_last_rep) begin
            r_state <= S_EMIT;
          end else begin
            r_cnt   <= '0;
            r_state <= S_CLEAR;
          end
        end
        S_EMIT: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_osc   <= r_osc;
            res_sum   <= r_err ? '0 : r_acc;
            res_err   <= r_err;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            if (w_last_osc) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              osc_sel <= '0;
            end else begin
              r_state <= S_SELECT;
              r_osc   <= r_osc + SEL_W'(1);
              osc_sel <= r_osc + SEL_W'(1);
              r_acc   <= '0;
              r_rep   <= '0;
              r_err   <= 1'b0;
              r_cnt   <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Scoreboard bench for freq_scan_ctrl: behavioural meter model, expected
// records queued at scan start, independent monitor pops on each handshake.
module tb_freq_scan_ctrl;

  localparam int N_OSC    = 16;
  localparam int SEL_W    = 4;
  localparam int CNT_W    = 32;
  localparam int AVG_LOG2 = 2;
  localparam int SETTLE   = 16;
  localparam int TIMEOUT  = 300;
  localparam int RESOL    = 100;
  localparam int SW       = CNT_W + AVG_LOG2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] osc_sel;
  logic             meas_enable;
  logic             meas_lock;
  logic [CNT_W-1:0] meas_count;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [SEL_W-1:0] res_osc;
  logic [SW-1:0]    res_sum;
  logic             res_err;

  always #5 clock = ~clock;

  freq_scan_ctrl #(
    .N_OSC(N_OSC), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .osc_sel(osc_sel),
    .meas_enable(meas_enable), .meas_lock(meas_lock),
    .meas_count(meas_count), .res_valid(res_valid),
    .res_ready(res_ready), .res_osc(res_osc),
    .res_sum(res_sum), .res_err(res_err)
  );

  typedef struct {
    int            osc;
    logic [SW-1:0] sum;
    logic          err;
    int            nen;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] vals[N_OSC];
  bit alive[N_OSC];
  int stall_osc = -1;
  int stall_n = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Meter: counts RESOL cycles while enabled, then locks with the selected
  // oscillator's value. A held lock flushes only after 8 idle cycles on a
  // live oscillator; a dead oscillator never locks and never flushes.
  int             m_t;
  int             m_clr;
  logic [SEL_W-1:0] m_selq;
  always @(posedge clock) begin
    if (!reset_n) begin
      meas_lock  <= 1'b0;
      meas_count <= '0;
      m_t        <= 0;
      m_clr      <= 0;
      m_selq     <= '0;
    end else begin
      m_selq <= osc_sel;
      if (meas_enable) begin
        m_clr <= 0;
        if (!meas_lock && alive[osc_sel]) begin
          if (m_t == RESOL - 1) begin
            meas_lock  <= 1'b1;
            meas_count <= vals[osc_sel];
            m_t        <= 0;
          end else begin
            m_t <= m_t + 1;
          end
        end
      end else begin
        m_t <= 0;
        if (meas_lock && alive[osc_sel] && osc_sel == m_selq) begin
          if (m_clr == 7) begin
            meas_lock <= 1'b0;
            m_clr     <= 0;
          end else begin
            m_clr <= m_clr + 1;
          end
        end else begin
          m_clr <= 0;
        end
      end
    end
  end

  always begin
    @(posedge clock);
    #2;
    if (res_valid && int'(res_osc) == stall_osc && stall_n < 50) begin
      res_ready = 1'b0;
      stall_n++;
    end else begin
      res_ready = 1'b1;
    end
  end

  int               en_cnt = 0;
  logic             prev_en = 1'b0;
  logic             prev_valid = 1'b0;
  logic             prev_done = 1'b0;
  logic [SEL_W-1:0] prev_sel = '0;
  logic [SEL_W-1:0] s_osc;
  logic [SW-1:0]    s_sum;
  logic             s_err;
  rec_t             e;

  always @(negedge clock) begin
    if (!reset_n) begin
      en_cnt     = 0;
      prev_en    = 1'b0;
      prev_valid = 1'b0;
      prev_done  = 1'b0;
      prev_sel   = osc_sel;
    end else begin
      if (meas_enable && !prev_en) en_cnt++;
      if (osc_sel != prev_sel)
        chk("sel_change_while_enabled", {prev_en, meas_enable}, 0);
      if (done) begin
        done_cnt++;
        chk("done_pulse_width", prev_done, 0);
      end
      if (res_valid && prev_valid) begin
        chk("hold_osc", res_osc, s_osc);
        chk("hold_sum", res_sum, s_sum);
        chk("hold_err", res_err, s_err);
      end else if (res_valid) begin
        s_osc = res_osc;
        s_sum = res_sum;
        s_err = res_err;
      end
      if (res_valid && !res_ready)
        chk("stall_enable", meas_enable, 0);
      if (res_valid && res_ready) begin
        chk("record_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rec_osc", res_osc, e.osc);
          chk("rec_sum", res_sum, e.sum);
          chk("rec_err", res_err, e.err);
          chk("rec_meas_count", en_cnt, e.nen);
        end
        en_cnt = 0;
      end
      prev_en    = meas_enable;
      prev_valid = res_valid;
      prev_done  = done;
      prev_sel   = osc_sel;
    end
  end

  task automatic pulse_start();
    @(posedge clock);
    #2 start = 1'b1;
    @(posedge clock);
    #2 start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_osc_sel"}, osc_sel, 0);
    chk({tag, "_meas_enable"}, meas_enable, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_osc"}, res_osc, 0);
    chk({tag, "_res_sum"}, res_sum, 0);
    chk({tag, "_res_err"}, res_err, 0);
  endtask

  // mode 0: 1000+k, 1: random, 2: all-ones counts
  task automatic run_scan(input int dead, input int dead_en, input int stall,
                          input bit dbl_start, input bit rst7, input int mode);
    int d0;
    rec_t r;
    bit hit;
    for (int k = 0; k < N_OSC; k++) begin
      unique case (mode)
        0: vals[k] = CNT_W'(1000 + k);
        1: vals[k] = $urandom();
        default: vals[k] = '1;
      endcase
      alive[k] = (k != dead);
      r.osc = k;
      r.err = (k == dead);
      r.sum = r.err ? '0 : SW'(longint'(vals[k]) * (1 << AVG_LOG2));
      r.nen = r.err ? dead_en : (1 << AVG_LOG2);
      exp_q.push_back(r);
    end
    stall_osc = stall;
    stall_n = 0;
    d0 = done_cnt;
    pulse_start();
    if (dbl_start) begin
      repeat (200) @(posedge clock);
      #2 chk("busy_mid_scan", busy, 1);
      pulse_start();
    end
    if (rst7) begin
      hit = 0;
      for (int i = 0; i < 20000 && !hit; i++) begin
        @(negedge clock);
        hit = (osc_sel == 4'd7) && meas_enable;
      end
      chk("reach_osc7_measure", hit, 1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      @(posedge clock);
      #1 check_reset_outputs("midscan_reset");
      reset_n = 1'b1;
      exp_q.delete();
      repeat (5) @(posedge clock);
      return;
    end
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clock);
    chk("done_seen", done_cnt - d0, 1);
    repeat (30) @(negedge clock);
    chk("done_single", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("records_left", exp_q.size(), 0);
    if (stall >= 0) chk("stall_length", stall_n, 50);
  endtask

  initial begin
    for (int k = 0; k < N_OSC; k++) begin
      alive[k] = 1'b1;
      vals[k] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("por");
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    run_scan(-1, 0, -1, 1'b1, 1'b0, 0);
    run_scan(5, 0, -1, 1'b0, 1'b0, 1);
    run_scan(-1, 0, 3, 1'b0, 1'b0, 1);
    run_scan(-1, 0, -1, 1'b0, 1'b0, 2);
    run_scan(-1, 0, -1, 1'b0, 1'b1, 1);
    run_scan(0, 1, -1, 1'b0, 1'b0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
